hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core. It sits beside the ID-stage instruction decoder and takes that decoder's per-instruction register fields, write-enable and timing classes. It tracks every in-flight register write across `NSTAGE` post-ID stages and produces the ID stall request and the ID-stage forwarding selects. It also keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- `NSTAGE`, 3: tracked stages after ID. Stage 0 is EX, stage `NSTAGE-1` is WB.
- `AW`, 5: register address width.
- `TW`, 2: Tnew/Tuse field width. Must satisfy `2**TW > NSTAGE-1`.
- `SW`, `$clog2(NSTAGE+1)`: forward-select width (localparam).

Ports (`clk` and `reset`: one clock, reset asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous; invalidates all tracked entries.
- `id_valid` in 1: the ID instruction is real, not a bubble.
- `id_rs`, `id_rt` in AW: source registers read by the ID instruction.
- `id_use_rs`, `id_use_rt` in 1: the source is actually read.
- `id_tuse_rs`, `id_tuse_rt` in TW: cycles after ID until the source is consumed. 0 means consumed in ID (beq, jr).
- `id_we` in 1: the ID instruction writes the GRF.
- `id_dst` in AW: destination register.
- `id_tnew` in TW: cycles, counted from EX entry, until the result is forwardable. Values: ALU 1, lw 2, jal 0.
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX.
- `fwd_rs_sel`, `fwd_rt_sel` out SW: ID operand source. 0 means GRF; k+1 means the stage-k result.
- `stall_cnt` out 32: saturating count of stall cycles.

## Operation
- Entry array `e[0..NSTAGE-1]`. Each entry holds `{v, we, dst, tnew}`.
- An entry matches source `r` when all of the following hold: `v`, `we`, `dst == r`, `r != 0`, and the corresponding `id_use_*` is set.
- Stall: `stall = id_valid & (hit_rs | hit_rt)`. `hit_rs` is true if the youngest (lowest k) matching entry for `id_rs` has `tnew > id_tuse_rs`. `hit_rt` is defined the same way for `id_rt`.
- Forwarding: `fwd_rs_sel = k+1` when the youngest match for `id_rs` is at stage k and `tnew == 0`. Otherwise `fwd_rs_sel = 0`. Older matches are always ignored. `fwd_rt_sel` is defined the same way.
- Register 0 never matches, never stalls and never forwards.
- Update on each clock edge:
  - `e[k+1] <= {e[k].v, e[k].we, e[k].dst, sat_dec(e[k].tnew)}`. `sat_dec` floors at 0.
  - `e[0] <= stall ? bubble : {id_valid, id_we, id_dst, id_tnew}`. A bubble has `v=0`.
  - The entry shifted out of `e[NSTAGE-1]` is dropped; that is the GRF write cycle.
- `flush` has priority over the shift: all `v` go to 0 and `stall_cnt` is unchanged.
- `stall_cnt` increments on every cycle in which `stall=1` and `flush=0`. It saturates at `32'hFFFF_FFFF`.

## Timing
- `stall` and `fwd_*_sel` are combinational from registered entries and ID inputs. There is no cycle of latency, so the decoder's outputs must be stable within the ID cycle.
- Reset values: all `v=0`, `we=0`, `dst=0`, `tnew=0`; `stall_cnt=0`. With all entries invalid, `stall=0` and `fwd_rs_sel=fwd_rt_sel=0`.
- Reset asserted mid-stall clears everything immediately. `stall` drops in the same cycle, not at the next edge.
- Load-use with `tuse=0` stalls exactly `id_tnew` cycles. Each stall cycle the blocking entry advances and its `tnew` drops by 1.
- Simultaneous `stall` and `flush`: flush wins and no bubble entry is written.
- `id_valid=0` never stalls and still inserts a bubble.

## Structure
- Shared package (`hazard_pkg`):
  - entry struct/typedef `{v, we, dst, tnew}`;
  - `TNEW_ALU=1`, `TNEW_LW=2`, `TNEW_JAL=0`;
  - `TUSE_ID=0`, `TUSE_EX=1`, `TUSE_MEM=2`;
  - `FWD_GRF=0`.
- One sub-module, `hazard_match`: a combinational youngest-match search for one source register that returns `{hit, stall_req, fwd_sel}`. It is instantiated twice, for rs and rt.
- The top level holds the entry shift register, the flush/reset logic and the stall counter.

## Test plan
- **Load into ID branch:** `lw $1` (tnew 2), then `beq $1,$0` (tuse_rs 0).
  - Expect `stall=1` for 2 cycles.
  - On the third cycle expect `stall=0` and `fwd_rs_sel=3` (WB). `stall_cnt=2`.
- **ALU into EX consumer:** `addu $3` (tnew 1), then `ori $4,$3` (tuse_rs 1).
  - Expect `stall=0` and `fwd_rs_sel=0` throughout.
- **Register 0:** `lw $0`, then `jr $0`.
  - Expect `stall=0` and `fwd_rs_sel=0`.
- **Youngest-match priority:** `addu $5`, `ori $5`, `jr $5` (tuse 0).
  - Expect a 1-cycle stall.
  - Then expect `fwd_rs_sel=2` (the ori entry, now at stage 1), not 3.
- **Reset mid-stall:** assert `reset` in the middle of a `lw $1` → `beq $1` stall.
  - Expect `stall=0`, `stall_cnt=0` and all selects 0 immediately.
  - After release, re-issuing `beq $1` does not stall.
- **Flush during stall:** `flush=1` together with `stall=1`.
  - On the next cycle all entries are invalid, `stall=0`, and `stall_cnt` is unchanged for the flushed cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard unit: decoder timing classes
// and the forward-select encoding for "read the register file".
package hazard_pkg;

    // Tnew: cycles after EX entry until the result can be forwarded.
    localparam int TNEW_JAL = 0;
    localparam int TNEW_ALU = 1;
    localparam int TNEW_LW  = 2;

    // Tuse: cycles after ID until the operand is consumed.
    localparam int TUSE_ID  = 0;
    localparam int TUSE_EX  = 1;
    localparam int TUSE_MEM = 2;

    // Forward select 0 means "no bypass, use the GRF read data".
    localparam int FWD_GRF  = 0;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match search for one ID source register across the in-flight
// write entries. Reports whether any entry matches, whether the youngest
// match forces a stall, and which stage (if any) can bypass the value.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int SW     = $clog2(NSTAGE + 1)
) (
    input  logic [NSTAGE-1:0]         ent_v,
    input  logic [NSTAGE-1:0]         ent_we,
    input  logic [NSTAGE-1:0][AW-1:0] ent_dst,
    input  logic [NSTAGE-1:0][TW-1:0] ent_tnew,
    input  logic [AW-1:0]             src,
    input  logic                      use_src,
    input  logic [TW-1:0]             tuse,
    output logic                      hit,
    output logic                      stall_req,
    output logic [SW-1:0]             fwd_sel
);

    // Scan from EX outward; the first match is the youngest producer and
    // every older match behind it is ignored.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        hit       = 1'b0;
        stall_req = 1'b0;
        fwd_sel   = SW'(FWD_GRF);
        for (int k = 0; k < NSTAGE; k++) begin
            if (!hit && use_src && (src != '0) && ent_v[k] && ent_we[k] &&
                (ent_dst[k] == src)) begin
                hit       = 1'b1;
                stall_req = (ent_tnew[k] > tuse);
                fwd_sel   = (ent_tnew[k] == '0) ? SW'(k + 1) : SW'(FWD_GRF);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit for the pipelined MIPS core. Tracks in-flight GRF
// writes for NSTAGE stages after ID (stage 0 = EX, NSTAGE-1 = WB), drives
// the ID stall request and ID forward selects, and counts stall cycles.
// TW must be wide enough that 2**TW > NSTAGE-1.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NSTAGE = 3,
    parameter  int AW     = 5,
    parameter  int TW     = 2,
    localparam int SW     = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic          id_we,
    input  logic [AW-1:0] id_dst,
    input  logic [TW-1:0] id_tnew,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic [31:0]   stall_cnt
);

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
    } entry_t;

    entry_t [NSTAGE-1:0] e_q, e_d;
    logic   [31:0]       stall_cnt_q, stall_cnt_d;

    logic [NSTAGE-1:0]         ent_v, ent_we;
    logic [NSTAGE-1:0][AW-1:0] ent_dst;
    logic [NSTAGE-1:0][TW-1:0] ent_tnew;

    logic rs_hit, rs_stall, rt_hit, rt_stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

    for (genvar k = 0; k < NSTAGE; k++) begin : g_flat
        assign ent_v[k]    = e_q[k].v;
        assign ent_we[k]   = e_q[k].we;
        assign ent_dst[k]  = e_q[k].dst;
        assign ent_tnew[k] = e_q[k].tnew;
    end

    hazard_match #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .SW(SW)) u_match_rs (
        .ent_v     (ent_v),
        .ent_we    (ent_we),
        .ent_dst   (ent_dst),
        .ent_tnew  (ent_tnew),
        .src       (id_rs),
        .use_src   (id_use_rs),
        .tuse      (id_tuse_rs),
        .hit       (rs_hit),
        .stall_req (rs_stall),
        .fwd_sel   (fwd_rs_sel)
    );

    hazard_match #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW), .SW(SW)) u_match_rt (
        .ent_v     (ent_v),
        .ent_we    (ent_we),
        .ent_dst   (ent_dst),
        .ent_tnew  (ent_tnew),
        .src       (id_rt),
        .use_src   (id_use_rt),
        .tuse      (id_tuse_rt),
        .hit       (rt_hit),
        .stall_req (rt_stall),
        .fwd_sel   (fwd_rt_sel)
    );

    // Stall is purely combinational from registered entries, so an async
    // reset drops it in the same cycle. Bubbles in ID never stall.
    assign stall     = id_valid & ((rs_hit & rs_stall) | (rt_hit & rt_stall));
    assign stall_cnt = stall_cnt_q;

    // Next entry state: flush invalidates everything, otherwise age all
    // entries by one stage and load EX with the ID instruction or a bubble.
    always_comb begin
        e_d = e_q;
        if (flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                e_d[k].v = 1'b0;
            end
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                e_d[k]      = e_q[k-1];
                e_d[k].tnew = sat_dec(e_q[k-1].tnew);
            end
            if (stall) begin
                e_d[0] = '0;
            end else begin
                e_d[0].v    = id_valid;
                e_d[0].we   = id_we;
                e_d[0].dst  = id_dst;
                e_d[0].tnew = id_tnew;
            end
        end
    end

    // Saturating stall-cycle counter; flushed cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours in the shift chain.
        if (reset) begin
            e_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a queue-based reference model
// of in-flight writes (aged by issue time) checked every cycle, plus
// directed instruction sequences with literal expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NSTAGE = 3;
    localparam int AW     = 5;
    localparam int TW     = 2;
    localparam int SW     = $clog2(NSTAGE + 1);

    logic          clk;
    logic          reset;
    logic          flush;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_dst;
    logic          id_use_rs, id_use_rt, id_we;
    logic [TW-1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
    logic [31:0]   stall_cnt;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  done     = 0;

    hazard_scoreboard #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_we      (id_we),
        .id_dst     (id_dst),
        .id_tnew    (id_tnew),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted writing instruction is remembered with the edge number
    // at which it entered EX; its stage and remaining latency follow from
    // its age. Youngest first in the queue.
    typedef struct {
        int edge_n;
        int dst;
        int tnew;
    } wr_t;

    wr_t         mq[$];
    int          m_edge = 0;
    int unsigned m_cnt  = 0;

    function automatic void m_src(input int r, input bit use_r, input int tuse,
                                  output bit st, output int fsel);
        st   = 0;
        fsel = 0;
        if (!use_r || r == 0) return;
        foreach (mq[i]) begin
            int age = m_edge - mq[i].edge_n;
            if (age < NSTAGE && mq[i].dst == r) begin
                int rem = (mq[i].tnew > age) ? mq[i].tnew - age : 0;
                st   = rem > tuse;
                fsel = (rem == 0) ? age + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic void m_eval(output bit st, output int frs, output int frt);
        bit s_rs, s_rt;
        m_src(int'(id_rs), id_use_rs, int'(id_tuse_rs), s_rs, frs);
        m_src(int'(id_rt), id_use_rt, int'(id_tuse_rt), s_rt, frt);
        st = id_valid && (s_rs || s_rt);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_cnt  = 0;
                m_edge = 0;
            end else begin
                bit st;
                int frs, frt;
                m_eval(st, frs, frt);
                if (flush) begin
                    mq.delete();
                end else begin
                    m_edge++;
                    if (st) m_cnt++;
                    if (!st && id_valid && id_we)
                        mq.push_front('{edge_n: m_edge, dst: int'(id_dst), tnew: int'(id_tnew)});
                    while (mq.size() > 0 && (m_edge - mq[$].edge_n) >= NSTAGE)
                        void'(mq.pop_back());
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            bit st;
            int frs, frt;
            @(negedge clk);
            if (done) break;
            m_eval(st, frs, frt);
            check("model stall", {31'd0, stall}, {31'd0, st});
            check("model fwd_rs", 32'(fwd_rs_sel), 32'(frs));
            check("model fwd_rt", 32'(fwd_rt_sel), 32'(frt));
            check("model stall_cnt", stall_cnt, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs, input bit urs, input int trs,
                         input int rt, input bit urt, input int trt,
                         input bit we, input int dst, input int tnew);
        id_valid   = v;
        id_rs      = AW'(rs);
        id_use_rs  = urs;
        id_tuse_rs = TW'(trs);
        id_rt      = AW'(rt);
        id_use_rt  = urt;
        id_tuse_rt = TW'(trt);
        id_we      = we;
        id_dst     = AW'(dst);
        id_tnew    = TW'(tnew);
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        bubble();
        repeat (NSTAGE + 1) step();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bubble();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset fwd_rs", 32'(fwd_rs_sel), 32'd0);
        check("reset fwd_rt", 32'(fwd_rt_sel), 32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);

        // Load into ID branch: lw $1 ; beq $1,$0
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, TNEW_LW);
        step();
        drive(1, 1, 1, TUSE_ID, 0, 1, TUSE_ID, 0, 0, 0);
        #1 check("lw-beq stall c1", {31'd0, stall}, 32'd1);
        step();
        #1 check("lw-beq stall c2", {31'd0, stall}, 32'd1);
        step();
        #1 check("lw-beq stall c3", {31'd0, stall}, 32'd0);
        check("lw-beq fwd_rs wb", 32'(fwd_rs_sel), 32'd3);
        check("lw-beq stall_cnt", stall_cnt, 32'd2);
        step();
        drain();

        // ALU into EX consumer: addu $3 ; ori $4,$3
        drive(1, 0, 0, 0, 0, 0, 0, 1, 3, TNEW_ALU);
        step();
        drive(1, 3, 1, TUSE_EX, 0, 0, 0, 1, 4, TNEW_ALU);
        #1 check("alu-ex stall", {31'd0, stall}, 32'd0);
        check("alu-ex fwd_rs", 32'(fwd_rs_sel), 32'd0);
        step();
        drain();

        // Register 0: lw $0 ; jr $0
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, TNEW_LW);
        step();
        drive(1, 0, 1, TUSE_ID, 0, 0, 0, 0, 0, 0);
        #1 check("r0 stall", {31'd0, stall}, 32'd0);
        check("r0 fwd_rs", 32'(fwd_rs_sel), 32'd0);
        step();
        drain();

        // Youngest match: addu $5 ; ori $5 ; jr $5
        drive(1, 0, 0, 0, 0, 0, 0, 1, 5, TNEW_ALU);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 5, TNEW_ALU);
        step();
        drive(1, 5, 1, TUSE_ID, 0, 0, 0, 0, 0, 0);
        #1 check("young stall", {31'd0, stall}, 32'd1);
        step();
        #1 check("young no stall", {31'd0, stall}, 32'd0);
        check("young fwd_rs", 32'(fwd_rs_sel), 32'd2);
        check("young stall_cnt", stall_cnt, 32'd3);
        step();
        drain();

        // Invalid ID instruction never stalls
        drive(1, 0, 0, 0, 0, 0, 0, 1, 6, TNEW_LW);
        step();
        drive(0, 6, 1, TUSE_ID, 0, 0, 0, 0, 0, 0);
        #1 check("invalid no stall", {31'd0, stall}, 32'd0);
        step();
        drain();

        // rt path: lw $7 ; sw rt=$7 (MEM use) ; bubble ; beq $0,$7
        drive(1, 0, 0, 0, 0, 0, 0, 1, 7, TNEW_LW);
        step();
        drive(1, 0, 0, 0, 7, 1, TUSE_MEM, 0, 0, 0);
        #1 check("sw-rt stall", {31'd0, stall}, 32'd0);
        check("sw-rt fwd_rt", 32'(fwd_rt_sel), 32'd0);
        step();
        bubble();
        step();
        drive(1, 0, 1, TUSE_ID, 7, 1, TUSE_ID, 0, 0, 0);
        #1 check("beq-rt stall", {31'd0, stall}, 32'd0);
        check("beq-rt fwd_rt", 32'(fwd_rt_sel), 32'd3);
        check("beq-rt stall_cnt", stall_cnt, 32'd3);
        step();
        drain();

        // Reset mid-stall: lw $1 ; beq $1
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, TNEW_LW);
        step();
        drive(1, 1, 1, TUSE_ID, 0, 0, 0, 0, 0, 0);
        #1 check("pre-reset stall", {31'd0, stall}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid-reset stall", {31'd0, stall}, 32'd0);
        check("mid-reset stall_cnt", stall_cnt, 32'd0);
        check("mid-reset fwd_rs", 32'(fwd_rs_sel), 32'd0);
        check("mid-reset fwd_rt", 32'(fwd_rt_sel), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("post-reset beq stall", {31'd0, stall}, 32'd0);
        step();
        drain();

        // Flush during stall: lw $2 ; beq $2 (one stall, then flush)
        drive(1, 0, 0, 0, 0, 0, 0, 1, 2, TNEW_LW);
        step();
        drive(1, 2, 1, TUSE_ID, 0, 0, 0, 0, 0, 0);
        #1 check("flush pre stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b1;
        #1 check("flush cycle stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        #1 check("after flush stall", {31'd0, stall}, 32'd0);
        check("after flush fwd_rs", 32'(fwd_rs_sel), 32'd0);
        check("after flush stall_cnt", stall_cnt, 32'd1);
        step();
        drain();

        done = 1'b1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
